// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data RAM between the core load/store
// path (C) and the DMA/image loader (D). Round-robin with bounded bursts,
// address bounds checking, and the RAM address/data/write-enable mux.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wd      core request, write flag, word address, write data
//   c_gnt/c_rd/c_err            core access performed, read data, out-of-range flag
//   d_*                         same set for the DMA requester
//   mem_we/mem_address/mem_wd   RAM write enable, word address, write data
//   mem_rd                      RAM read data (combinational from mem_address)
//   owner                       0=IDLE, 1=OWN_C, 2=OWN_D
//   err_sticky                  any out-of-range access since reset
module dmem_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 150000,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [31:0]       c_addr,
  input  logic [DATA_W-1:0] c_wd,
  output logic              c_gnt,
  output logic [DATA_W-1:0] c_rd,
  output logic              c_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wd,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rd,
  output logic              d_err,
  output logic              mem_we,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [1:0]        owner,
  output logic              err_sticky
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = $clog2(MAX_BURST + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [ADDR_W-1:0] DEPTH    = ADDR_W'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_C = 2'd1,
    OWN_D = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_d_q, last_d_d;   // 1: D owned last, so C wins a tie
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             c_in_range, d_in_range;

  assign owner      = state_q;
  assign err_sticky = err_q;

  // State register; reset leaves C as the winner of the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Grants, bounds check and RAM mux; owner is IDLE in reset so all of this is 0
  always_comb begin
    c_in_range  = c_addr < DEPTH;
    d_in_range  = d_addr < DEPTH;
    c_gnt       = (state_q == OWN_C) && c_req;
    d_gnt       = (state_q == OWN_D) && d_req;
    mem_we      = 1'b0;
    mem_address = '0;
    mem_wd      = '0;
    c_rd        = '0;
    d_rd        = '0;
    c_err       = 1'b0;
    d_err       = 1'b0;
    if (c_gnt) begin
      mem_address = c_addr;
      mem_wd      = c_wd;
      mem_we      = c_we && c_in_range;
      c_rd        = c_in_range ? mem_rd : '0;
      c_err       = !c_in_range;
    end else if (d_gnt) begin
      mem_address = d_addr;
      mem_wd      = d_wd;
      mem_we      = d_we && d_in_range;
      d_rd        = d_in_range ? mem_rd : '0;
      d_err       = !d_in_range;
    end
  end

  // Ownership: handover costs no idle cycle; burst count saturates so a lone
  // owner keeps going, and the waiting side takes over right after the
  // MAX_BURST-th access
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    err_d    = err_q || c_err || d_err;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (c_req && d_req) state_d = last_d_q ? OWN_C : OWN_D;
        else if (c_req)     state_d = OWN_C;
        else if (d_req)     state_d = OWN_D;
      end
      OWN_C: begin
        if (!c_req) begin
          last_d_d = 1'b0;
          cnt_d    = '0;
          state_d  = d_req ? OWN_D : IDLE;
        end else if (d_req && (cnt_q == CNT_LAST)) begin
          last_d_d = 1'b0;
          cnt_d    = '0;
          state_d  = OWN_D;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OWN_D: begin
        if (!d_req) begin
          last_d_d = 1'b1;
          cnt_d    = '0;
          state_d  = c_req ? OWN_C : IDLE;
        end else if (c_req && (cnt_q == CNT_LAST)) begin
          last_d_d = 1'b1;
          cnt_d    = '0;
          state_d  = OWN_C;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural
// RAM and a transaction-level reference model for the randomized phase.
module tb_dmem_arbiter;

  localparam int unsigned DW        = 32;
  localparam int unsigned DEPTH     = 150000;
  localparam int unsigned MAX_BURST = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          c_req, c_we, d_req, d_we;
  logic [31:0]   c_addr, d_addr;
  logic [DW-1:0] c_wd, d_wd;
  logic          c_gnt, d_gnt, c_err, d_err;
  logic [DW-1:0] c_rd, d_rd;
  logic          mem_we;
  logic [31:0]   mem_address;
  logic [DW-1:0] mem_wd, mem_rd;
  logic [1:0]    owner;
  logic          err_sticky;

  int checks = 0;
  int errors = 0;

  bit [31:0] ram [DEPTH];

  dmem_arbiter #(.DATA_W(DW), .MEM_DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd),
    .c_gnt(c_gnt), .c_rd(c_rd), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
    .d_gnt(d_gnt), .d_rd(d_rd), .d_err(d_err),
    .mem_we(mem_we), .mem_address(mem_address), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .owner(owner), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM
  assign mem_rd = (mem_address < DEPTH) ? ram[mem_address[17:0]] : '0;
  always @(posedge clk) if (mem_we && mem_address < DEPTH) ram[mem_address[17:0]] <= mem_wd;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_addr = 0; c_wd = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wd = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    c_req = 1; c_we = 1; c_addr = 9;  c_wd = 32'hBAD0BAD0;
    d_req = 1; d_we = 1; d_addr = 10; d_wd = 32'h0BAD0BAD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({c_gnt, d_gnt, mem_we, c_err, d_err, err_sticky} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000", {c_gnt, d_gnt, mem_we, c_err, d_err, err_sticky});
    end
    checks++;
    if ({mem_address, mem_wd, c_rd, d_rd} !== 128'b0) begin
      errors++;
      $display("FAIL reset_buses got %h want 0", {mem_address, mem_wd, c_rd, d_rd});
    end
    checks++;
    if (owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_owner got %0d want 0", owner);
    end
    checks++;
    if (ram[9] !== 32'h0 || ram[10] !== 32'h0) begin
      errors++;
      $display("FAIL reset_write_blocked got %h %h want 0 0", ram[9], ram[10]);
    end
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_write_read();
    c_req = 1; c_we = 1; c_addr = 5; c_wd = 32'hA5A5;
    #1;
    checks++;
    if (owner !== 2'd0 || c_gnt !== 1'b0) begin
      errors++;
      $display("FAIL wr_latency got owner=%0d gnt=%b want 0 0", owner, c_gnt);
    end
    step();
    @(negedge clk);
    checks++;
    if (owner !== 2'd1 || c_gnt !== 1'b1) begin
      errors++;
      $display("FAIL wr_grant got owner=%0d gnt=%b want 1 1", owner, c_gnt);
    end
    checks++;
    if ({mem_we, mem_address, mem_wd} !== {1'b1, 32'd5, 32'hA5A5}) begin
      errors++;
      $display("FAIL wr_membus got we=%b a=%0d wd=%h want 1 5 a5a5", mem_we, mem_address, mem_wd);
    end
    step();
    c_we = 0;
    @(negedge clk);
    checks++;
    if (c_gnt !== 1'b1 || c_rd !== 32'hA5A5 || c_err !== 1'b0) begin
      errors++;
      $display("FAIL rd_back got gnt=%b rd=%h err=%b want 1 a5a5 0", c_gnt, c_rd, c_err);
    end
    step();
    c_req = 0;
    step();
  endtask

  task automatic test_tie();
    do_reset();
    c_req = 1; d_req = 1;
    step();
    @(negedge clk);
    checks++;
    if ({c_gnt, d_gnt, owner} !== {1'b1, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL tie_first got c=%b d=%b owner=%0d want 1 0 1", c_gnt, d_gnt, owner);
    end
    step();
    c_req = 0; d_req = 0;
    step();
    c_req = 1; d_req = 1;
    step();
    @(negedge clk);
    checks++;
    if ({c_gnt, d_gnt, owner} !== {1'b0, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL tie_after_c got c=%b d=%b owner=%0d want 0 1 2", c_gnt, d_gnt, owner);
    end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_continuous();
    logic exp_c, exp_d;
    c_req = 1; d_req = 1;
    for (int k = 0; k <= 64; k++) begin
      @(negedge clk);
      exp_c = (k >= 1) && (((k - 1) / MAX_BURST) % 2 == 0);
      exp_d = (k >= 1) && !exp_c;
      checks++;
      if ({c_gnt, d_gnt} !== {exp_c, exp_d}) begin
        errors++;
        $display("FAIL continuous cycle %0d got c=%b d=%b want %b %b", k, c_gnt, d_gnt, exp_c, exp_d);
      end
      step();
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_lone();
    d_req = 1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if ({c_gnt, d_gnt} !== {1'b0, k >= 1}) begin
        errors++;
        $display("FAIL lone cycle %0d got c=%b d=%b want 0 %b", k, c_gnt, d_gnt, k >= 1);
      end
      step();
    end
    c_req = 1;
    @(negedge clk);
    checks++;
    if ({c_gnt, d_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL lone_last got c=%b d=%b want 0 1", c_gnt, d_gnt);
    end
    step();
    @(negedge clk);
    checks++;
    if ({c_gnt, d_gnt, owner} !== {1'b1, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL lone_handover got c=%b d=%b owner=%0d want 1 0 1", c_gnt, d_gnt, owner);
    end
    step();
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_range();
    do_reset();
    d_req = 1; d_we = 1; d_addr = 150000; d_wd = 32'hDEADBEEF;
    step();
    @(negedge clk);
    checks++;
    if ({d_gnt, d_err, mem_we, err_sticky} !== 4'b1100) begin
      errors++;
      $display("FAIL range_oob_write got gnt=%b err=%b we=%b sticky=%b want 1 1 0 0", d_gnt, d_err, mem_we, err_sticky);
    end
    step();
    d_addr = 149999; d_wd = 32'h12345678;
    @(negedge clk);
    checks++;
    if (err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL range_sticky got %b want 1", err_sticky);
    end
    checks++;
    if ({d_gnt, d_err, mem_we, mem_address} !== {3'b101, 32'd149999}) begin
      errors++;
      $display("FAIL range_last_write got gnt=%b err=%b we=%b a=%0d want 1 0 1 149999", d_gnt, d_err, mem_we, mem_address);
    end
    step();
    d_we = 0;
    @(negedge clk);
    checks++;
    if (d_rd !== 32'h12345678 || d_err !== 1'b0) begin
      errors++;
      $display("FAIL range_last_read got rd=%h err=%b want 12345678 0", d_rd, d_err);
    end
    step();
    d_addr = 150000;
    @(negedge clk);
    checks++;
    if (d_rd !== 32'h0 || d_err !== 1'b1) begin
      errors++;
      $display("FAIL range_oob_read got rd=%h err=%b want 0 1", d_rd, d_err);
    end
    step();
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_req = 1; d_we = 1; d_addr = 7; d_wd = 32'h07070707;
    step();
    step();
    step();
    checks++;
    if ({d_gnt, mem_we, owner} !== {2'b11, 2'd2}) begin
      errors++;
      $display("FAIL midrst_before got gnt=%b we=%b owner=%0d want 1 1 2", d_gnt, mem_we, owner);
    end
    #2;
    rst_n = 0;
    c_req = 1;
    #1;
    checks++;
    if ({d_gnt, c_gnt, mem_we, owner} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_drop got d=%b c=%b we=%b owner=%0d want 0 0 0 0", d_gnt, c_gnt, mem_we, owner);
    end
    @(negedge clk);
    rst_n = 1;
    step();
    @(negedge clk);
    checks++;
    if ({c_gnt, d_gnt, owner} !== {1'b1, 1'b0, 2'd1}) begin
      errors++;
      $display("FAIL midrst_tie got c=%b d=%b owner=%0d want 1 0 1", c_gnt, d_gnt, owner);
    end
    step();
    idle_inputs();
    step();
    step();
  endtask

  // Mostly in-range scratch addresses, plus words straddling the top boundary
  function automatic logic [31:0] rnd_addr();
    int unsigned r;
    r = $urandom_range(0, 15);
    if (r < 12)      return 32'(1000 + $urandom_range(0, 15));
    else if (r < 14) return 32'(149995 + $urandom_range(0, 3));
    else             return 32'(150000 + $urandom_range(0, 3));
  endfunction

  // Reference model: who holds the RAM, how many accesses it has made this
  // tenure, and who held it last; expected RAM contents kept in a map
  task automatic test_random();
    int          m_own, m_last, m_run, oth;
    bit          m_sticky, mine, other;
    bit [31:0]   mm [int unsigned];
    logic        ecg, edg, cin, din, ece, ede;
    logic [64:0] ebus;
    logic [31:0] ecrd, edrd;

    do_reset();
    m_own = 0; m_last = 2; m_run = 0; m_sticky = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      cin  = c_addr < DEPTH;
      din  = d_addr < DEPTH;
      ecg  = (m_own == 1) && c_req;
      edg  = (m_own == 2) && d_req;
      ece  = ecg && !cin;
      ede  = edg && !din;
      ebus = ecg ? {c_we && cin, c_addr, c_wd} : edg ? {d_we && din, d_addr, d_wd} : 65'b0;
      ecrd = (ecg && cin) ? (mm.exists(c_addr) ? mm[c_addr] : 32'h0) : 32'h0;
      edrd = (edg && din) ? (mm.exists(d_addr) ? mm[d_addr] : 32'h0) : 32'h0;

      checks++;
      if ({c_gnt, d_gnt} !== {ecg, edg}) begin
        errors++;
        $display("FAIL rnd_gnt n=%0d got %b%b want %b%b", n, c_gnt, d_gnt, ecg, edg);
      end
      checks++;
      if (owner !== 2'(m_own)) begin
        errors++;
        $display("FAIL rnd_owner n=%0d got %0d want %0d", n, owner, m_own);
      end
      checks++;
      if ({mem_we, mem_address, mem_wd} !== ebus) begin
        errors++;
        $display("FAIL rnd_membus n=%0d got %h want %h", n, {mem_we, mem_address, mem_wd}, ebus);
      end
      checks++;
      if ({c_rd, d_rd} !== {ecrd, edrd}) begin
        errors++;
        $display("FAIL rnd_rdata n=%0d got %h %h want %h %h", n, c_rd, d_rd, ecrd, edrd);
      end
      checks++;
      if ({c_err, d_err} !== {ece, ede}) begin
        errors++;
        $display("FAIL rnd_err n=%0d got %b%b want %b%b", n, c_err, d_err, ece, ede);
      end
      checks++;
      if (err_sticky !== m_sticky) begin
        errors++;
        $display("FAIL rnd_sticky n=%0d got %b want %b", n, err_sticky, m_sticky);
      end

      // Advance the model by one clock edge
      if (ecg && c_we && cin) mm[c_addr] = c_wd;
      if (edg && d_we && din) mm[d_addr] = d_wd;
      m_sticky = m_sticky | ece | ede;
      if (m_own == 0) begin
        m_run = 0;
        if (c_req && d_req) m_own = (m_last == 2) ? 1 : 2;
        else if (c_req)     m_own = 1;
        else if (d_req)     m_own = 2;
      end else begin
        mine  = (m_own == 1) ? c_req : d_req;
        other = (m_own == 1) ? d_req : c_req;
        oth   = 3 - m_own;
        if (!mine) begin
          m_last = m_own;
          m_own  = other ? oth : 0;
          m_run  = 0;
        end else begin
          m_run++;
          if (other && m_run >= int'(MAX_BURST)) begin
            m_last = m_own;
            m_own  = oth;
            m_run  = 0;
          end
        end
      end

      step();
      // A requester holds its request until granted, then may change it
      if (!c_req || ecg) begin
        c_req  = ($urandom_range(0, 3) != 0);
        c_we   = $urandom_range(0, 1) == 1;
        c_addr = rnd_addr();
        c_wd   = $urandom;
      end
      if (!d_req || edg) begin
        d_req  = ($urandom_range(0, 3) != 0);
        d_we   = $urandom_range(0, 1) == 1;
        d_addr = rnd_addr();
        d_wd   = $urandom;
      end
    end
    idle_inputs();
    step();
    step();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_write_read();
    test_tie();
    test_continuous();
    test_lone();
    test_range();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
